inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter M_WIDTH, default 8, memory data width in bits.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width in bits (multiple of M_WIDTH).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, program counter width.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: run  in  1  enables instruction sequencing.
REQ-008 SHALL have ports: mem_req  out  1 / mem_addr  out  ADDR_WIDTH / mem_ready  in  1 / mem_rdata  in  M_WIDTH  byte-fetch handshake.
REQ-009 SHALL have ports: inst  out  INST_WIDTH  assembled instruction / dec_en  out  1 / dec_ready  in  1  decode-stage handshake.
REQ-010 SHALL have ports: exec_start  out  1 / exec_done  in  1 / exec_branch  in  1 / exec_target  in  ADDR_WIDTH / exec_halt  in  1  execute handshake.
REQ-011 SHALL have ports: pc  out  ADDR_WIDTH / busy  out  1 / halted  out  1  status.

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, DEC_WAIT, EXEC, EXEC_WAIT, HALT.
REQ-013 IDLE: SHALL go to FETCH on the cycle after run is sampled 1, with byte index 0.
REQ-014 FETCH: SHALL hold mem_req=1 and mem_addr=pc+byte index (mod 2^ADDR_WIDTH), and ignore mem_rdata while mem_ready=0.
REQ-015 FETCH: on each cycle with mem_ready=1, SHALL store mem_rdata little-endian into inst[M_WIDTH*idx +: M_WIDTH] and increment idx.
REQ-016 SHALL go to DECODE after accepting byte INST_WIDTH/M_WIDTH-1, with mem_req=0 from that next cycle onward.
REQ-017 DECODE: SHALL assert dec_en for exactly one cycle, then enter DEC_WAIT.
REQ-018 DEC_WAIT: SHALL wait for dec_ready=1, then enter EXEC; dec_ready in other states is ignored.
REQ-019 EXEC: SHALL assert exec_start for exactly one cycle, then enter EXEC_WAIT.
REQ-020 EXEC_WAIT: on exec_done=1, SHALL update the PC: exec_halt=1 keeps pc and enters HALT; otherwise pc becomes exec_target if exec_branch=1, else pc+INST_WIDTH/M_WIDTH (mod 2^ADDR_WIDTH).
REQ-021 On the same EXEC_WAIT exit, SHALL go to FETCH if run=1, else IDLE; exec_halt takes priority over exec_branch.
REQ-022 SHALL ignore exec_done outside EXEC_WAIT.
REQ-023 run deasserted mid-instruction SHALL NOT abort; the current instruction completes, then the block enters IDLE.
REQ-024 inst SHALL remain stable from DECODE entry until the next FETCH byte is accepted.
REQ-025 busy SHALL be 1 in all states except IDLE and HALT; halted SHALL be 1 only in HALT, which exits only via rst.
REQ-026 With zero-wait memory, dec_ready on time and immediate exec_done, an instruction SHALL take 8 cycles (4 fetch, DECODE, DEC_WAIT, EXEC, EXEC_WAIT) for the default parameters.

Reset
REQ-027 rst=1 SHALL, at the clock edge, force state=IDLE, pc=RESET_PC, idx=0, inst=0, and mem_req, dec_en, exec_start, busy and halted all 0; this overrides any state, including mid-fetch and HALT.
REQ-028 The first fetch after rst is released SHALL use mem_addr=RESET_PC.

Configuration
REQ-029 Macro INST_SEQUENCER_RETIRE_CNT_EN defined: SHALL add output retire_cnt (16 bits, reset 0), incremented on each non-halt EXEC_WAIT exit and wrapping 0xFFFF->0.
REQ-030 Macro undefined: the retire_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Scenario: reset, run=1, mem_ready=1, memory bytes 13,05,10,00 at 0..3, exec_done given in the first EXEC_WAIT cycle -> inst=0x00100513, pc=4 after 8 cycles.
REQ-032 Scenario: mem_ready low 3 cycles on byte 2 -> mem_addr holds pc+2, byte not stored, no dec_en until all 4 bytes are accepted.
REQ-033 Scenario: pc=0xFC, no branch -> next fetch addresses are 0xFC..0xFF, then pc=0x00.
REQ-034 Scenario: exec_branch=1, exec_target=0x40 -> next mem_addr=0x40; with exec_halt=1 also set -> HALT, halted=1, pc unchanged, no mem_req.
REQ-035 Scenario: rst pulsed during FETCH byte 1 -> next cycle state IDLE, mem_req=0, pc=RESET_PC; run=0 mid-EXEC_WAIT -> IDLE after exec_done, busy=0.
REQ-036 Scenario (macro defined): 3 instructions retired -> retire_cnt=3; a halting instruction does not increment it.

Source files
------------

// File: rtl/inst_sequencer.sv
// Fetches an instruction byte by byte, then sequences decode and execute handshakes and updates the PC.
// Optional retire counter is enabled by defining INST_SEQUENCER_RETIRE_CNT_EN.
module inst_sequencer #(
   parameter int M_WIDTH    = 8,
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [M_WIDTH-1:0]    mem_rdata,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  dec_en,
   input  logic                  dec_ready,
   output logic                  exec_start,
   input  logic                  exec_done,
   input  logic                  exec_branch,
   input  logic [ADDR_WIDTH-1:0] exec_target,
   input  logic                  exec_halt,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  halted
`ifdef INST_SEQUENCER_RETIRE_CNT_EN
   ,
   output logic [15:0]           retire_cnt
`endif
);

   localparam int BYTES = INST_WIDTH / M_WIDTH;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(BYTES);
   localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_DECODE    = 3'd2;
   localparam logic [2:0] ST_DEC_WAIT  = 3'd3;
   localparam logic [2:0] ST_EXEC      = 3'd4;
   localparam logic [2:0] ST_EXEC_WAIT = 3'd5;
   localparam logic [2:0] ST_HALT      = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;

   // Next-state, byte assembly and PC update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      idx_d   = idx_q;
      inst_d  = inst_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
               idx_d   = {IDX_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (mem_ready) begin
               inst_d[M_WIDTH*idx_q +: M_WIDTH] = mem_rdata;
               if (idx_q == LAST_IDX) begin
                  idx_d   = {IDX_W{1'b0}};
                  state_d = ST_DECODE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: state_d = ST_DEC_WAIT;
         ST_DEC_WAIT: begin
            if (dec_ready) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_DEC_WAIT;
            end
         end
         ST_EXEC: state_d = ST_EXEC_WAIT;
         ST_EXEC_WAIT: begin
            // Halt wins over branch and freezes the PC.
            if (exec_done) begin
               if (exec_halt) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = exec_branch ? exec_target : (pc_q + PC_STEP);
                  state_d = run ? ST_FETCH : ST_IDLE;
               end
            end else begin
               state_d = ST_EXEC_WAIT;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_INIT;
         idx_q   <= {IDX_W{1'b0}};
         inst_q  <= {INST_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         idx_q   <= idx_d;
         inst_q  <= inst_d;
      end
   end

`ifdef INST_SEQUENCER_RETIRE_CNT_EN
   logic [15:0] retire_q;

   // Count every non-halting instruction completion; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q <= 16'd0;
      end else if (state_q == ST_EXEC_WAIT && exec_done && !exec_halt) begin
         retire_q <= retire_q + 16'd1;
      end else begin
         retire_q <= retire_q;
      end
   end

   assign retire_cnt = retire_q;
`endif

   assign mem_req    = (state_q == ST_FETCH);
   assign mem_addr   = pc_q + ADDR_WIDTH'(idx_q);
   assign inst       = inst_q;
   assign dec_en     = (state_q == ST_DECODE);
   assign exec_start = (state_q == ST_EXEC);
   assign pc         = pc_q;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized scoreboard bench for inst_sequencer plus directed timing, reset and halt checks.
module tb_inst_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, run, mem_req, mem_ready, dec_en, dec_ready;
   logic       exec_start, exec_done, exec_branch, exec_halt, busy, halted;
   logic [7:0] mem_addr, mem_rdata, exec_target, pc;
   logic [31:0] inst;
`ifdef INST_SEQUENCER_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   inst_sequencer dut (
      .clk(clk), .rst(rst), .run(run),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .inst(inst), .dec_en(dec_en), .dec_ready(dec_ready),
      .exec_start(exec_start), .exec_done(exec_done), .exec_branch(exec_branch),
      .exec_target(exec_target), .exec_halt(exec_halt),
      .pc(pc), .busy(busy), .halted(halted)
`ifdef INST_SEQUENCER_RETIRE_CNT_EN
      , .retire_cnt(retire_cnt)
`endif
   );

   typedef struct {
      logic       branch;
      logic [7:0] target;
      logic       halt;
   } plan_t;

   int errors = 0;
   int checks = 0;
   logic [7:0]  mem [0:255];
   plan_t       plan_q[$];
   logic [7:0]  exp_addr_q[$];
   logic [31:0] exp_inst_q[$];
   logic [7:0]  exp_pc_q[$];
   int ready_pct, dec_pct, done_pct;
   bit run_rand, noise_en, mon_en, armed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Environment: memory responder, decode/execute responders, optional random run.
   always begin
      plan_t p;
      @(posedge clk);
      #1;
      if (rst) armed = 1'b0;
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      mem_rdata = mem_ready ? mem[mem_addr] : 8'($urandom);
      dec_ready = ($urandom_range(0, 99) < dec_pct);
      if (run_rand) run = ($urandom_range(0, 99) < 85);
      exec_done   = 1'b0;
      exec_branch = 1'b0;
      exec_halt   = 1'b0;
      exec_target = 8'($urandom);
      if (armed && ($urandom_range(0, 99) < done_pct)) begin
         p = '{branch: 1'b0, target: 8'h00, halt: 1'b0};
         if (plan_q.size() > 0) p = plan_q.pop_front();
         exec_done   = 1'b1;
         exec_branch = p.branch;
         exec_target = p.target;
         exec_halt   = p.halt;
         armed       = 1'b0;
      end else if (!armed && noise_en) begin
         exec_done   = ($urandom_range(0, 3) == 0);
         exec_branch = 1'($urandom);
         exec_halt   = 1'($urandom);
      end
      if (exec_start) armed = 1'b1;
   end

   // Monitor: compare each accepted fetch, decode and execute event against the expected queues.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (mem_req && mem_ready) begin
            if (exp_addr_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL fetch_unexpected: got addr %0h expected no fetch", mem_addr);
            end else chk("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
         end
         if (dec_en) begin
            if (exp_inst_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL decode_unexpected: got inst %0h expected no decode", inst);
            end else chk("dec_inst", inst, exp_inst_q.pop_front());
         end
         if (exec_start) begin
            if (exp_pc_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL exec_unexpected: got pc %0h expected no exec", pc);
            end else chk("exec_pc", 32'(pc), 32'(exp_pc_q.pop_front()));
         end
      end
   end

   initial begin
      logic [7:0]  pc_m;
      logic [7:0]  a;
      logic [31:0] w;
      int          retire_m;
      int          cyc;
      plan_t       p;
      localparam int N = 24;

      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00; dec_ready = 1'b0;
      exec_done = 1'b0; exec_branch = 1'b0; exec_target = 8'h00; exec_halt = 1'b0;
      ready_pct = 100; dec_pct = 100; done_pct = 100;
      run_rand = 1'b0; noise_en = 1'b0; mon_en = 1'b0; armed = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

      step(); step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_dec_en", 32'(dec_en), 32'd0);
      chk("rst_exec_start", 32'(exec_start), 32'd0);
      rst = 1'b0;

      // Directed: reset during fetch byte 1, then zero-wait instruction timing.
      plan_q.push_back('{branch: 1'b0, target: 8'h00, halt: 1'b0});
      run = 1'b1;
      step();
      chk("first_fetch_req", 32'(mem_req), 32'd1);
      chk("first_fetch_addr", 32'(mem_addr), 32'd0);
      step();
      chk("byte1_addr", 32'(mem_addr), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midfetch_rst_req", 32'(mem_req), 32'd0);
      chk("midfetch_rst_pc", 32'(pc), 32'd0);
      chk("midfetch_rst_busy", 32'(busy), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k <= 4) begin
            chk("tim_fetch_req", 32'(mem_req), 32'd1);
            chk("tim_fetch_addr", 32'(mem_addr), 32'(k - 1));
            chk("tim_fetch_dec", 32'(dec_en), 32'd0);
         end else if (k == 5) begin
            chk("tim_dec_en", 32'(dec_en), 32'd1);
            chk("tim_inst", inst, 32'h0010_0513);
            chk("tim_dec_req", 32'(mem_req), 32'd0);
         end else if (k == 6) begin
            chk("tim_decwait_dec", 32'(dec_en), 32'd0);
            chk("tim_decwait_exec", 32'(exec_start), 32'd0);
            chk("tim_decwait_busy", 32'(busy), 32'd1);
         end else if (k == 7) begin
            chk("tim_exec_start", 32'(exec_start), 32'd1);
            run = 1'b0;
         end else if (k == 8) begin
            chk("tim_execwait_start", 32'(exec_start), 32'd0);
            chk("tim_execwait_busy", 32'(busy), 32'd1);
            chk("tim_execwait_pc", 32'(pc), 32'd0);
         end else begin
            chk("run_low_idle_busy", 32'(busy), 32'd0);
            chk("run_low_idle_req", 32'(mem_req), 32'd0);
            chk("after_inst_pc", 32'(pc), 32'd4);
         end
      end
      run = 1'b1;
      step();
      chk("resume_fetch_addr", 32'(mem_addr), 32'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run = 1'b0;

      // Randomized: build the program plan and its expected fetch/decode/exec trace.
      plan_q.delete();
      pc_m = 8'h00;
      retire_m = 0;
      for (int i = 0; i < N; i++) begin
         p.halt   = (i == N - 1);
         p.branch = (i == N - 1) || (i == 2) || ((i != 3) && ($urandom_range(0, 99) < 30));
         p.target = (i == 2) ? 8'hFC : 8'($urandom);
         plan_q.push_back(p);
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            a = pc_m + 8'(k);
            exp_addr_q.push_back(a);
            w = w | (32'(mem[a]) << (8 * k));
         end
         exp_inst_q.push_back(w);
         exp_pc_q.push_back(pc_m);
         if (!p.halt) begin
            pc_m = p.branch ? p.target : pc_m + 8'd4;
            retire_m++;
         end
      end

      ready_pct = 70; dec_pct = 50; done_pct = 40;
      run_rand = 1'b1; noise_en = 1'b1; mon_en = 1'b1;
      cyc = 0;
      while (!halted && cyc < 20000) begin
         step();
         cyc++;
      end
      checks++;
      if (!halted) begin
         errors++;
         $display("FAIL halt_timeout: got halted=0 after %0d cycles expected halted=1", cyc);
      end
      for (int k = 0; k < 6; k++) begin
         chk("halt_flag", 32'(halted), 32'd1);
         chk("halt_busy", 32'(busy), 32'd0);
         chk("halt_no_req", 32'(mem_req), 32'd0);
         chk("halt_pc", 32'(pc), 32'(pc_m));
         step();
      end
      chk("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
      chk("inst_q_left", 32'(exp_inst_q.size()), 32'd0);
      chk("pc_q_left", 32'(exp_pc_q.size()), 32'd0);
`ifdef INST_SEQUENCER_RETIRE_CNT_EN
      chk("retire_cnt", 32'(retire_cnt), 32'(retire_m));
`endif
      mon_en = 1'b0;
      run_rand = 1'b0;
      run = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("halt_rst_halted", 32'(halted), 32'd0);
      chk("halt_rst_pc", 32'(pc), 32'd0);
      chk("halt_rst_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
